// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path: address width,
// the hard-wired zero register, and the request payload used by producers.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_age_counter.sv
// Saturating count of consecutive cycles the execute request was refused;
// force_grant tells the arbiter that execute must win this cycle.
module regfile_wb_age_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic force_grant
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (waiting && (wait_cnt_q < MAX_CNT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_grant = (wait_cnt_q >= MAX_CNT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between execute and load producers.
// Load has fixed priority; the age counter bounds execute starvation.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN     = regfile_pkg::XLEN,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_wd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_wd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd
);

  // Handshake: a transfer happens on a port when valid && ready in the same
  // cycle; the requester holds rd/wd stable while valid && !ready.

  logic    force_grant;
  logic    rf_we_q, rf_we_d;
  wb_req_t rf_req_q, rf_req_d;

  regfile_wb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk         (clk),
    .rst_n       (rst_n),
    .waiting     (ex_valid && !ex_ready),
    .clear       (!ex_valid || ex_ready),
    .force_grant (force_grant)
  );

  assign ex_ready = ex_valid && (!ld_valid || force_grant);
  assign ld_ready = ld_valid && !ex_ready;

  always_comb begin
    rf_we_d  = 1'b0;
    rf_req_d = rf_req_q;
    if (ex_ready) begin
      rf_we_d  = (ex_rd != ZERO_REG);
      rf_req_d = '{rd: ex_rd, wd: ex_wd};
    end else if (ld_ready) begin
      rf_we_d  = (ld_rd != ZERO_REG);
      rf_req_d = '{rd: ld_rd, wd: ld_wd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q  <= 1'b0;
      rf_req_q <= '0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_req_q <= rf_req_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_rd = rf_req_q.rd;
  assign rf_wd = rf_req_q.wd;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every
// cycle, plus hand-computed expectations at the interesting cycles.
module tb_regfile_wb_arbiter;

  localparam int XLEN     = 64;
  localparam int MAX_WAIT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ld_valid;
  logic            ex_ready, ld_ready;
  logic [4:0]      ex_rd, ld_rd;
  logic [XLEN-1:0] ex_wd, ld_wd;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_rd    (ex_rd),
    .ex_wd    (ex_wd),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_rd    (ld_rd),
    .ld_wd    (ld_wd),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wd    (rf_wd)
  );

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run-length of refused execute cycles plus the
  // write that the register file should see next cycle.
  int              refused_run = 0;
  logic            m_we = 1'b0;
  logic [4:0]      m_rd = '0;
  logic [XLEN-1:0] m_wd = '0;
  logic [XLEN-1:0] bank [32];

  function automatic logic exp_ex_grant();
    return ex_valid && (!ld_valid || refused_run >= MAX_WAIT);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        refused_run = 0;
        m_we = 1'b0;
        m_rd = '0;
        m_wd = '0;
      end else begin
        if (exp_ex_grant()) begin
          m_we = (ex_rd != 0); m_rd = ex_rd; m_wd = ex_wd;
          refused_run = 0;
        end else if (ld_valid) begin
          m_we = (ld_rd != 0); m_rd = ld_rd; m_wd = ld_wd;
          refused_run = ex_valid ? refused_run + 1 : 0;
        end else begin
          m_we = 1'b0;
          refused_run = 0;
        end
      end
    end
  end

  // Scoreboard compare, mid-cycle; also plays the downstream register file.
  initial begin
    for (int i = 0; i < 32; i++) bank[i] = '0;
    forever begin
      @(negedge clk);
      chk("ex_ready", XLEN'(ex_ready), XLEN'(exp_ex_grant()));
      chk("ld_ready", XLEN'(ld_ready), XLEN'(ld_valid && !exp_ex_grant()));
      chk("rf_we", XLEN'(rf_we), XLEN'(m_we));
      chk("rf_rd", XLEN'(rf_rd), XLEN'(m_rd));
      chk("rf_wd", rf_wd, m_wd);
      if (rf_we) bank[rf_rd] = rf_wd;
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b1; ex_rd = 5'd7; ex_wd = 64'h0000_0000_0000_0E07;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_wd = 64'h0000_0000_0000_0103;
    repeat (3) next_cycle();

    // reset held with both valids high
    mid();
    chk("rst_we", XLEN'(rf_we), 64'd0);
    chk("rst_rd", XLEN'(rf_rd), 64'd0);
    chk("rst_wd", rf_wd, 64'd0);
    chk("rst_ld_first", XLEN'(ld_ready), 64'd1);

    // contention: ld wins first, then ex once ld drops
    next_cycle(); rst_n = 1'b1;
    mid(); chk("c0_ld_ready", XLEN'(ld_ready), 64'd1);
    chk("c0_ex_ready", XLEN'(ex_ready), 64'd0);
    next_cycle(); ld_valid = 1'b0;
    mid(); chk("c1_ex_ready", XLEN'(ex_ready), 64'd1);
    chk("c1_rf_rd", XLEN'(rf_rd), 64'd3);
    chk("c1_rf_wd", rf_wd, 64'h103);
    next_cycle(); ex_valid = 1'b0;
    mid(); chk("c2_rf_rd", XLEN'(rf_rd), 64'd7);
    chk("c2_rf_we", XLEN'(rf_we), 64'd1);

    // single execute write
    next_cycle(); ex_valid = 1'b1; ex_rd = 5'd5; ex_wd = 64'hDEAD_BEEF;
    mid(); chk("single_ex_ready", XLEN'(ex_ready), 64'd1);
    next_cycle(); ex_valid = 1'b0;
    mid(); chk("single_we", XLEN'(rf_we), 64'd1);
    chk("single_rd", XLEN'(rf_rd), 64'd5);
    chk("single_wd", rf_wd, 64'hDEAD_BEEF);
    next_cycle();
    mid(); chk("single_we_after", XLEN'(rf_we), 64'd0);
    chk("single_rd_hold", XLEN'(rf_rd), 64'd5);

    // write to x0 is accepted but suppressed
    next_cycle(); ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = 64'h1234;
    mid(); chk("x0_ld_ready", XLEN'(ld_ready), 64'd1);
    next_cycle(); ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 64'hAAAA_5555;
    mid(); chk("x0_we", XLEN'(rf_we), 64'd0);
    chk("x0_wd", rf_wd, 64'h1234);
    next_cycle(); ld_valid = 1'b0;
    mid(); chk("r9_we", XLEN'(rf_we), 64'd1);

    // starvation bound: ex refused 4 cycles, granted in the 5th
    ex_rd = 5'd12; ex_wd = 64'hC0DE;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      ex_valid = 1'b1; ld_valid = 1'b1;
      ld_rd = 5'(16 + i); ld_wd = 64'(32'h100 + i);
      mid();
      chk("starve_ex_ready", XLEN'(ex_ready), XLEN'(i == 4));
      chk("starve_ld_ready", XLEN'(ld_ready), XLEN'(i != 4));
    end

    // ex_valid dropping while refused restarts the wait
    next_cycle(); ex_valid = 1'b0;
    next_cycle(); ex_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid(); chk("restart_ex_ready", XLEN'(ex_ready), XLEN'(i == 4));
      next_cycle();
    end

    // reset while a captured write is pending
    ex_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 64'hBBBB;
    mid(); chk("mid_rst_ld_ready", XLEN'(ld_ready), 64'd1);
    @(posedge clk); #1;
    chk("mid_rst_captured", XLEN'(rf_we), 64'd1);
    rst_n = 1'b0; ld_valid = 1'b0;
    #1 chk("mid_rst_we_async", XLEN'(rf_we), 64'd0);
    chk("mid_rst_wd_async", rf_wd, 64'd0);
    next_cycle(); next_cycle(); rst_n = 1'b1;
    next_cycle();
    mid(); chk("r9_retained", bank[9], 64'hAAAA_5555);

    // back-to-back throughput: ld then ex on alternate cycles
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ld_valid = (i % 2 == 0); ld_rd = 5'(i + 1); ld_wd = 64'(i * 3);
      ex_valid = 1'b1; ex_rd = 5'(i + 8); ex_wd = 64'(i * 5);
    end
    next_cycle(); ex_valid = 1'b0; ld_valid = 1'b0;
    repeat (2) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two producers: the execute pipeline (ALU results) and the load unit (memory results). Each producer presents a valid/ready request carrying a destination register and 64-bit data. The arbiter grants at most one request per cycle and drives a registered write (we/rd/wd) into the register file one cycle later. The load unit has fixed priority, and an aging counter bounds how long execute can be starved.

## Interface
- XLEN, 64, data width of the write data path
- MAX_WAIT, 4, consecutive cycles execute may be refused while valid before it is force-granted (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- ex_valid  input  1  execute request valid
- ex_ready  output  1  execute request accepted this cycle (combinational)
- ex_rd  input  5  execute destination register
- ex_wd  input  XLEN  execute write data
- ld_valid  input  1  load request valid
- ld_ready  output  1  load request accepted this cycle (combinational)
- ld_rd  input  5  load destination register
- ld_wd  input  XLEN  load write data
- rf_we  output  1  register file write enable (registered)
- rf_rd  output  5  register file write select (registered)
- rf_wd  output  XLEN  register file write data (registered)

## Operation
- Transfer on a port = valid && ready in the same cycle. Requesters hold rd/wd stable while valid && !ready.
- The write port accepts every cycle, so ready depends only on arbitration. At most one of ex_ready and ld_ready is high.
- Grant rule:
  - ex granted iff ex_valid && (!ld_valid || wait_cnt ≥ MAX_WAIT).
  - Otherwise ld granted iff ld_valid.
- wait_cnt is internal, width $clog2(MAX_WAIT+1), reset 0:
  - Cleared when ex transfers or ex_valid is low.
  - Incremented when ex_valid && !ex_ready.
  - Saturates at MAX_WAIT.
- Write to x0: the request is accepted (ready high, handshake completes), but the registered output has rf_we=0.
- Output register at each clk edge:
  - On a transfer: rf_we <= (rd != 0), rf_rd <= granted rd, rf_wd <= granted wd.
  - With no transfer: rf_we <= 0, and rf_rd/rf_wd hold their previous values.
- Ordering: grants are never reordered beyond the rule above. Same-rd hazards between the two producers are resolved upstream.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, wait_cnt=0. ex_ready/ld_ready follow the grant rule combinationally and are low whenever their valid is low.
- Latency: transfer in cycle N → rf_we/rf_rd/rf_wd valid in cycle N+1 → register file updates at the end of N+1.
- Throughput: one write per cycle, sustained.
- Starvation bound: with ld_valid held high, an ex request waits at most MAX_WAIT cycles and transfers in cycle MAX_WAIT+1 of its validity. Load resumes priority the following cycle.
- Simultaneous valid with wait_cnt < MAX_WAIT: ld wins and wait_cnt increments.
- ex_valid dropping while refused: wait_cnt clears. Upstream must not do this; the behaviour is still defined.
- Reset asserted mid-operation:
  - Outputs and wait_cnt clear immediately.
  - A write captured but not yet applied is lost.
  - Readies are low while valids are low; requesters re-present after reset.

## Structure
- Shared package regfile_pkg:
  - REG_ADDR_W=5
  - ZERO_REG=5'd0
  - XLEN default
  - typedef wb_req_t {rd, wd}, reused by both producers and the output stage
- One sub-module: regfile_wb_age_counter. It holds the saturating wait counter with inputs clk, rst_n, waiting, clear, and output force (wait_cnt ≥ MAX_WAIT).
- Grant logic and the output register stay in the top module.

## Test plan
- Reset: hold rst_n=0 with both valids high → rf_we=0, rf_rd=0, rf_wd=0. Release rst_n → first grant goes to ld.
- Single ex: ex_valid=1, ex_rd=5, ex_wd=64'hDEAD_BEEF for 1 cycle → ex_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_wd=64'hDEAD_BEEF; following cycle rf_we=0.
- x0 drop: ld_valid=1, ld_rd=0, ld_wd=64'h1234 → ld_ready=1; next cycle rf_we=0.
- Contention: both valid, ld_rd=3/ex_rd=7, ld released after 1 cycle → cycle 0 grants ld (rf_rd=3 at cycle 1), cycle 1 grants ex (rf_rd=7 at cycle 2).
- Starvation: ld_valid held high with new data every cycle, ex_valid held high, MAX_WAIT=4 → ex_ready low for cycles 0–3, high in cycle 4; ld regains priority in cycle 5.
- Reset mid-write: transfer ld_rd=9 in cycle N, assert rst_n=0 in cycle N+1 before the edge → rf_we drops to 0 asynchronously; after release, register 9 retains its prior value as seen through the register file.
